// File: rtl/seg_pkg.sv
// Shared codes, encodings and helpers for the seven-segment display scheduler.
// Code values follow the external cathode decoder's 8-bit digit input space.
package seg_pkg;

    localparam int NUM_DIGITS  = 4;
    localparam int BCD_W       = 4 * NUM_DIGITS;
    localparam int CONV_W      = 14;
    localparam int CONV_CYCLES = CONV_W;

    localparam logic [CONV_W-1:0] MAX_SCORE = 14'd9999;

    localparam logic [7:0] CODE_S     = 8'h0A;
    localparam logic [7:0] CODE_R     = 8'h0B;
    localparam logic [7:0] CODE_C     = 8'h0C;
    localparam logic [7:0] CODE_E     = 8'h0E;
    localparam logic [7:0] CODE_L     = 8'h11;
    localparam logic [7:0] CODE_MINUS = 8'hFE;
    localparam logic [7:0] CODE_BLANK = 8'hFF;

    typedef logic [7:0] code_t;
    typedef code_t [NUM_DIGITS-1:0] digit_buf_t;

    // Index 0 is the rightmost digit, so "LOSE" reads L,O,S,E from digit 3 down.
    localparam digit_buf_t LOSE_TEXT = {CODE_L, 8'h00, CODE_S, CODE_E};
    localparam digit_buf_t BLANK_BUF = {NUM_DIGITS{CODE_BLANK}};

    typedef enum logic [1:0] {
        MODE_SCORE = 2'b00,
        MODE_LOSE  = 2'b01,
        MODE_BLANK = 2'b10,
        MODE_DASH  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_e;

    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] r;
        r = bcd;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    function automatic digit_buf_t blank_leading(input logic [BCD_W-1:0] bcd);
        digit_buf_t codes;
        logic       seen;
        seen = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            seen     = seen | (bcd[4*k +: 4] != 4'd0);
            codes[k] = seen ? {4'h0, bcd[4*k +: 4]} : CODE_BLANK;
        end
        codes[0] = {4'h0, bcd[3:0]};
        return codes;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble with IDLE/SHIFT/COMMIT control; 14 shift cycles then a one-cycle COMMIT.
// Latency: start to o_Done 15 cycles; no backpressure, i_Start is honoured in IDLE and in COMMIT.
module bin_to_bcd_seq
    import seg_pkg::*;
(
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    input  logic              i_Start,
    input  logic [CONV_W-1:0] i_Value,
    output logic              o_Busy,
    output logic              o_Done,
    output logic [BCD_W-1:0]  o_Bcd
);

    localparam int CNT_W = $clog2(CONV_CYCLES);

    conv_state_e       state_q, state_d;
    logic [CONV_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic [BCD_W-1:0]  adj;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        adj     = dabble_adjust(bcd_q);
        case (state_q)
            ST_IDLE: begin
                if (i_Start) begin
                    state_d = ST_SHIFT;
                    bin_d   = i_Value;
                    bcd_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                {bcd_d, bin_d} = {adj, bin_q} << 1;
                cnt_d          = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(CONV_CYCLES - 1)) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                // Result is held in bcd_q for this one cycle; a restart reloads immediately.
                if (i_Start) begin
                    state_d = ST_SHIFT;
                    bin_d   = i_Value;
                    bcd_d   = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_Busy = (state_q != ST_IDLE);
    assign o_Done = (state_q == ST_COMMIT);
    assign o_Bcd  = bcd_q;

endmodule

// File: rtl/seg_display_scheduler.sv
// Four-digit seven-segment scheduler: queued score conversion, leading-zero blanking, anode scan.
// Latency: load to lit digit 17 edges, mode 1 edge; no backpressure, one load queued (last wins).
module seg_display_scheduler
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int VAL_W       = 14
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_n,
    input  logic [VAL_W-1:0]      i_Value,
    input  logic                  i_Load,
    input  logic [1:0]            i_Mode,
    output logic [7:0]            o_Digit,
    output logic [NUM_DIGITS-1:0] o_Anode,
    output logic                  o_Busy
);

    localparam int EXT_W = (VAL_W > CONV_W) ? VAL_W : CONV_W;
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [EXT_W-1:0]      value_ext;
    logic [CONV_W-1:0]     value_sat;

    logic                  pend_q, pend_d;
    logic [CONV_W-1:0]     pend_val_q, pend_val_d;

    logic                  conv_start;
    logic [CONV_W-1:0]     conv_value;
    logic                  conv_busy;
    logic                  conv_done;
    logic [BCD_W-1:0]      conv_bcd;

    digit_buf_t            score_q, score_d;

    logic [CNT_W-1:0]      rcnt_q, rcnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    code_t                 digit_q, digit_d;

    assign value_ext = EXT_W'(i_Value);
    assign value_sat = (value_ext > EXT_W'(MAX_SCORE)) ? MAX_SCORE : value_ext[CONV_W-1:0];

    // A load on the COMMIT edge with nothing queued restarts directly, which is
    // indistinguishable from queuing it and restarting on the same edge.
    always_comb begin
        conv_start = 1'b0;
        conv_value = value_sat;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        if (!conv_busy) begin
            conv_start = i_Load;
        end else if (conv_done) begin
            if (pend_q) begin
                conv_start = 1'b1;
                conv_value = pend_val_q;
                pend_d     = i_Load;
                if (i_Load) begin
                    pend_val_d = value_sat;
                end
            end else if (i_Load) begin
                conv_start = 1'b1;
            end
        end else if (i_Load) begin
            pend_d     = 1'b1;
            pend_val_d = value_sat;
        end
    end

    bin_to_bcd_seq u_conv (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .i_Start (conv_start),
        .i_Value (conv_value),
        .o_Busy  (conv_busy),
        .o_Done  (conv_done),
        .o_Bcd   (conv_bcd)
    );

    always_comb begin
        score_d = score_q;
        if (conv_done) begin
            score_d = blank_leading(conv_bcd);
        end
    end

    always_comb begin
        rcnt_d = rcnt_q + CNT_W'(1);
        idx_d  = idx_q;
        if (rcnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            rcnt_d = '0;
            idx_d  = idx_q + IDX_W'(1);
        end
        anode_d = ~(NUM_DIGITS'(1) << idx_d);
        // Reads the committed buffer, so a fresh commit reaches o_Digit one edge later.
        case (i_Mode)
            MODE_SCORE: digit_d = score_q[idx_d];
            MODE_LOSE:  digit_d = LOSE_TEXT[idx_d];
            MODE_BLANK: digit_d = CODE_BLANK;
            default:    digit_d = CODE_MINUS;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            score_q    <= BLANK_BUF;
            rcnt_q     <= '0;
            idx_q      <= '0;
            anode_q    <= ~NUM_DIGITS'(1);
            digit_q    <= CODE_BLANK;
        end else begin
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            score_q    <= score_d;
            rcnt_q     <= rcnt_d;
            idx_q      <= idx_d;
            anode_q    <= anode_d;
            digit_q    <= digit_d;
        end
    end

    assign o_Digit = digit_q;
    assign o_Anode = anode_q;
    assign o_Busy  = conv_busy;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Bench for seg_display_scheduler: table vectors, multi-cycle corner sequences and random traffic
// compared every cycle against a transaction-timing model using decimal arithmetic.
module tb_seg_display_scheduler;

    localparam int RD       = 4;
    localparam int CONV_LAT = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] value;
    logic        load;
    logic [1:0]  mode;
    logic [7:0]  digit;
    logic [3:0]  anode;
    logic        busy;

    int checks = 0;
    int errors = 0;

    int         m_left;
    int         m_conv;
    int         m_pend_val;
    int         m_tick;
    bit         m_pend;
    int         m_disp [4];
    logic [7:0] m_digit;
    logic [3:0] m_anode;
    logic       m_busy;
    logic [7:0] lose_txt [4] = '{8'h0E, 8'h0A, 8'h00, 8'h11};
    int         g_dig [4];

    typedef struct {
        int          value;
        logic [1:0]  mode;
        logic [31:0] exp_codes;
    } vec_t;

    always #5 clk = ~clk;

    seg_display_scheduler #(.REFRESH_DIV(RD), .VAL_W(14)) dut (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .i_Value (value),
        .i_Load  (load),
        .i_Mode  (mode),
        .o_Digit (digit),
        .o_Anode (anode),
        .o_Busy  (busy)
    );

    function automatic int pow10(input int k);
        int r;
        r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    // Digit k is blank when the value has fewer than k+1 decimal digits (digit 0 never).
    function automatic int code_for(input int v, input int k);
        if (k > 0 && v < pow10(k)) return 255;
        return (v / pow10(k)) % 10;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_left     = 0;
        m_conv     = 0;
        m_pend     = 1'b0;
        m_pend_val = 0;
        m_tick     = 0;
        for (int k = 0; k < 4; k++) m_disp[k] = 255;
        m_digit = 8'hFF;
        m_anode = 4'b1110;
        m_busy  = 1'b0;
    endtask

    // m_left counts edges until the commit edge; a commit uses the value in flight.
    task automatic model_step(input logic rst_s, input logic ld, input int val, input logic [1:0] md);
        int sat;
        int idx;
        int old_disp [4];
        if (!rst_s) begin
            model_reset();
        end else begin
            sat      = (val > 9999) ? 9999 : val;
            old_disp = m_disp;
            if (m_left == 0) begin
                if (ld) begin
                    m_conv = sat;
                    m_left = CONV_LAT;
                end
            end else if (m_left == 1) begin
                for (int k = 0; k < 4; k++) m_disp[k] = code_for(m_conv, k);
                if (m_pend) begin
                    m_conv = m_pend_val;
                    m_left = CONV_LAT;
                    m_pend = ld;
                    if (ld) m_pend_val = sat;
                end else if (ld) begin
                    m_conv = sat;
                    m_left = CONV_LAT;
                end else begin
                    m_left = 0;
                end
            end else begin
                m_left--;
                if (ld) begin
                    m_pend     = 1'b1;
                    m_pend_val = sat;
                end
            end
            m_tick++;
            idx     = (m_tick / RD) % 4;
            m_anode = ~(4'b0001 << idx);
            case (md)
                2'b00:   m_digit = 8'(old_disp[idx]);
                2'b01:   m_digit = lose_txt[idx];
                2'b10:   m_digit = 8'hFF;
                default: m_digit = 8'hFE;
            endcase
            m_busy = (m_left != 0);
        end
    endtask

    task automatic cyc();
        model_step(rst_n, load, int'(value), mode);
        @(posedge clk);
        @(negedge clk);
        check("cyc_anode", 32'(anode), 32'(m_anode));
        check("cyc_digit", 32'(digit), 32'(m_digit));
        check("cyc_busy", 32'(busy), 32'(m_busy));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        load  = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic do_load(input int v);
        load  = 1'b1;
        value = 14'(v);
        cyc();
        load  = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            cyc();
        end
        if (n >= 100) check("idle_timeout", 32'(busy), 32'h0);
    endtask

    task automatic scan();
        for (int k = 0; k < 4; k++) g_dig[k] = -1;
        for (int c = 0; c < 4 * RD; c++) begin
            cyc();
            for (int k = 0; k < 4; k++) begin
                if (!anode[k]) g_dig[k] = int'(digit);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs [10];
        int   n;

        vecs[0] = '{1234,  2'b00, 32'h01020304};
        vecs[1] = '{7,     2'b00, 32'hFFFFFF07};
        vecs[2] = '{0,     2'b00, 32'hFFFFFF00};
        vecs[3] = '{16383, 2'b00, 32'h09090909};
        vecs[4] = '{50,    2'b00, 32'hFFFF0500};
        vecs[5] = '{1000,  2'b00, 32'h01000000};
        vecs[6] = '{9999,  2'b00, 32'h09090909};
        vecs[7] = '{1234,  2'b01, 32'h11000A0E};
        vecs[8] = '{1234,  2'b11, 32'hFEFEFEFE};
        vecs[9] = '{1234,  2'b10, 32'hFFFFFFFF};

        rst_n = 1'b0;
        load  = 1'b0;
        value = '0;
        mode  = 2'b00;
        @(negedge clk);
        cyc();
        check("reset_anode", 32'(anode), 32'h0000000E);
        check("reset_digit", 32'(digit), 32'h000000FF);
        check("reset_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;

        for (int i = 1; i <= 4 * RD; i++) begin
            cyc();
            if (i == RD) check("release_anode_4", 32'(anode), 32'h0000000D);
            if (i == 4 * RD) check("release_anode_16", 32'(anode), 32'h0000000E);
            if (i % RD == 0) check("release_digit", 32'(digit), 32'h000000FF);
        end

        for (int v = 0; v < 10; v++) begin
            do_reset();
            mode = vecs[v].mode;
            do_load(vecs[v].value);
            wait_idle(n);
            check($sformatf("table%0d_busy_len", v), 32'(n), 32'(CONV_LAT));
            repeat (2) cyc();
            scan();
            for (int k = 0; k < 4; k++) begin
                check($sformatf("table%0d_digit%0d", v, k), 32'(g_dig[k]),
                      {24'h0, vecs[v].exp_codes[8*k +: 8]});
            end
        end

        // Back-to-back: 345 is overwritten by 678 while 12 converts.
        do_reset();
        mode = 2'b00;
        n    = 0;
        do_load(12);
        for (int i = 0; i < 45; i++) begin
            if (busy) n++;
            load  = (i == 3 || i == 6);
            value = (i == 3) ? 14'd345 : 14'd678;
            cyc();
            if (i == 15) check("b2b_first_commit", 32'(digit), 32'h00000002);
        end
        load = 1'b0;
        check("b2b_busy_len", 32'(n), 32'd30);
        scan();
        check("b2b_d0", 32'(g_dig[0]), 32'h08);
        check("b2b_d1", 32'(g_dig[1]), 32'h07);
        check("b2b_d2", 32'(g_dig[2]), 32'h06);
        check("b2b_d3", 32'(g_dig[3]), 32'hFF);

        // Load arriving exactly on the COMMIT edge is not dropped.
        do_reset();
        do_load(11);
        repeat (14) cyc();
        do_load(22);
        check("commit_edge_busy", 32'(busy), 32'h1);
        wait_idle(n);
        check("commit_edge_len", 32'(n), 32'(CONV_LAT));
        scan();
        check("commit_edge_d0", 32'(g_dig[0]), 32'h02);
        check("commit_edge_d1", 32'(g_dig[1]), 32'h02);
        check("commit_edge_d2", 32'(g_dig[2]), 32'hFF);

        // Reset in mid-SHIFT discards the conversion.
        do_reset();
        do_load(4321);
        repeat (5) cyc();
        rst_n = 1'b0;
        cyc();
        check("midreset_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        repeat (2) cyc();
        scan();
        for (int k = 0; k < 4; k++) check($sformatf("midreset_d%0d", k), 32'(g_dig[k]), 32'hFF);
        mode = 2'b11;
        cyc();
        check("mode_latency", 32'(digit), 32'hFE);

        // Random traffic against the model.
        do_reset();
        mode = 2'b00;
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 799) != 0);
            load  = ($urandom_range(0, 15) == 0);
            value = 14'($urandom_range(0, 16383));
            if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
            cyc();
        end
        rst_n = 1'b1;
        load  = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
